// File: rtl/fifo_defs_pkg.sv
// Shared width derivations for the FIFO family; every FIFO variant sizes
// its pointers, count and storage address from these helpers.
package fifo_defs_pkg;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage for the FIFO: synchronous write, asynchronous read.
// The storage has no reset; only the pointers define which words are valid.
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy and threshold flags, overflow/underflow
// pulses, and either registered or first-word-fall-through read data.
module sync_fifo
    import fifo_defs_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        write,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        read,
    output logic [WIDTH-1:0]            rdata,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int ADDR_W = addr_width(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL must be below DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;

    // Occupancy comes straight from the pointer difference; the wrap bit
    // makes the modulo-2*DEPTH subtraction land in 0..DEPTH.
    assign count        = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still takes a write when a pop frees the head slot in the same cycle.
    always_comb begin
        pop         = read && !empty;
        push        = write && (!full || read);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rdata_d     = rdata_q;
        overflow_d  = write && full && !read;
        underflow_d = read && empty;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = head;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (push && !rst),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (head)
    );

    // In fall-through mode the head is shown directly; zero while empty
    // keeps the post-reset value the same as the registered mode.
    if (FWFT != 0) begin : g_fwft
        assign rdata = empty ? '0 : head;
    end else begin : g_reg
        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed checks of sync_fifo in registered-read and fall-through modes.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       wr0 = 1'b0, rd0 = 1'b0;
    logic [7:0] wd0 = 8'h00;
    logic [7:0] rdata0;
    logic [2:0] count0;
    logic       full0, empty0, af0, ae0, ov0, un0;

    logic       wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] wd1 = 8'h00;
    logic [7:0] rdata1;
    logic [2:0] count1;
    logic       full1, empty1, af1, ae1, ov1, un1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_dut0 (
        .clock(clk), .rst(rst), .write(wr0), .wdata(wd0), .read(rd0),
        .rdata(rdata0), .count(count0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ov0), .underflow(un0)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_dut1 (
        .clock(clk), .rst(rst), .write(wr1), .wdata(wd1), .read(rd1),
        .rdata(rdata1), .count(count1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step0(input logic w, input logic [7:0] d, input logic r);
        wr0 = w; wd0 = d; rd0 = r;
        @(posedge clk);
        #1;
        wr0 = 1'b0; rd0 = 1'b0;
    endtask

    task automatic step1(input logic w, input logic [7:0] d, input logic r);
        wr1 = w; wd1 = d; rd1 = r;
        @(posedge clk);
        #1;
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        // reset with a write pending: the write must be discarded
        rst = 1'b1;
        step0(1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_ae", ae0, 1);
        chk("rst_full", full0, 0);
        chk("rst_af", af0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_un", un0, 0);
        chk("rst_rdata", rdata0, 0);
        chk("rst_rdata_fwft", rdata1, 0);
        chk("rst_empty_fwft", empty1, 1);

        // fill, checking threshold flags at each level
        for (int i = 0; i < 4; i++) begin
            step0(1'b1, pat[i], 1'b0);
            chk("fill_count", count0, i + 1);
            chk("fill_ae", ae0, (i == 0) ? 1 : 0);
            chk("fill_af", af0, (i >= 2) ? 1 : 0);
            chk("fill_full", full0, (i == 3) ? 1 : 0);
            chk("fill_empty", empty0, 0);
        end

        // drain in order
        for (int i = 0; i < 4; i++) begin
            step0(1'b0, 8'h00, 1'b1);
            chk("drain_rdata", rdata0, pat[i]);
            chk("drain_count", count0, 3 - i);
        end
        chk("drain_empty", empty0, 1);
        step0(1'b0, 8'h00, 1'b0);
        chk("rdata_hold", rdata0, 8'h44);

        // refill, overflow, then full read+write
        for (int i = 0; i < 4; i++) step0(1'b1, pat[i], 1'b0);
        chk("refill_full", full0, 1);
        step0(1'b1, 8'h55, 1'b0);
        chk("ovf_pulse", ov0, 1);
        chk("ovf_count", count0, 4);
        step0(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", ov0, 0);
        step0(1'b1, 8'h66, 1'b1);
        chk("rw_full_rdata", rdata0, 8'h11);
        chk("rw_full_count", count0, 4);
        chk("rw_full_full", full0, 1);
        chk("rw_full_ov", ov0, 0);
        step0(1'b0, 8'h00, 1'b1);
        chk("rw_pop2", rdata0, 8'h22);
        step0(1'b0, 8'h00, 1'b1);
        chk("rw_pop3", rdata0, 8'h33);
        step0(1'b0, 8'h00, 1'b1);
        chk("rw_pop4", rdata0, 8'h44);
        step0(1'b0, 8'h00, 1'b1);
        chk("rw_pop5", rdata0, 8'h66);
        chk("rw_empty", empty0, 1);

        // read+write on empty: write lands, read is an underflow
        step0(1'b1, 8'h77, 1'b1);
        chk("ufl_rw_pulse", un0, 1);
        chk("ufl_rw_count", count0, 1);
        chk("ufl_rw_rdata", rdata0, 8'h66);
        step0(1'b0, 8'h00, 1'b1);
        chk("ufl_pop_rdata", rdata0, 8'h77);
        chk("ufl_pop_un", un0, 0);
        chk("ufl_pop_count", count0, 0);
        step0(1'b0, 8'h00, 1'b1);
        chk("ufl_only_pulse", un0, 1);
        chk("ufl_only_rdata", rdata0, 8'h77);
        chk("ufl_only_count", count0, 0);

        // ten push/pop pairs walk both pointers around twice
        for (int i = 0; i < 10; i++) begin
            step0(1'b1, 8'(8'h80 + i), 1'b0);
            chk("wrap_count", count0, 1);
            step0(1'b0, 8'h00, 1'b1);
            chk("wrap_rdata", rdata0, 8'h80 + i);
        end

        // fill, then reset with a write that would otherwise overflow
        for (int i = 0; i < 4; i++) step0(1'b1, 8'(i + 1), 1'b0);
        chk("pre_rst_full", full0, 1);
        rst = 1'b1;
        step0(1'b1, 8'h99, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count", count0, 0);
        chk("mid_rst_empty", empty0, 1);
        chk("mid_rst_rdata", rdata0, 0);
        chk("mid_rst_ov", ov0, 0);
        chk("mid_rst_un", un0, 0);
        chk("mid_rst_full", full0, 0);
        step0(1'b1, 8'h3C, 1'b0);
        step0(1'b0, 8'h00, 1'b1);
        chk("post_rst_rdata", rdata0, 8'h3C);

        // fall-through mode
        step1(1'b1, 8'hA5, 1'b0);
        chk("fwft_empty", empty1, 0);
        chk("fwft_rdata", rdata1, 8'hA5);
        chk("fwft_count", count1, 1);
        step1(1'b1, 8'hB6, 1'b0);
        chk("fwft_hold", rdata1, 8'hA5);
        chk("fwft_count2", count1, 2);
        step1(1'b0, 8'h00, 1'b1);
        chk("fwft_next", rdata1, 8'hB6);
        chk("fwft_count3", count1, 1);
        step1(1'b0, 8'h00, 1'b1);
        chk("fwft_drain_empty", empty1, 1);
        chk("fwft_drain_count", count1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold in entries.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports: clock input 1 (sole clock, all logic on rising edge); rst input 1 (synchronous, active-high reset).
REQ-007 SHALL have ports: write input 1 (push request); wdata input WIDTH (push data); read input 1 (pop request).
REQ-008 SHALL have ports: rdata output WIDTH (read data); count output $clog2(DEPTH)+1 (occupancy, 0..DEPTH).
REQ-009 SHALL have ports: full, empty, almost_full, almost_empty output 1 each (status); overflow, underflow output 1 each (one-cycle error pulses).

Function
REQ-010 SHALL keep write/read pointers of $clog2(DEPTH)+1 bits; the low bits address storage; pointers wrap modulo 2*DEPTH.
REQ-011 SHALL accept a push when write=1 and (full=0 or read=1), storing wdata at the write pointer and advancing it by 1.
REQ-012 SHALL accept a pop when read=1 and empty=0, advancing the read pointer by 1.
REQ-013 SHALL, when full, accept simultaneous read+write: the head is popped, wdata is stored, and count is unchanged.
REQ-014 SHALL, when empty, reject read even with simultaneous write; the write is accepted and count becomes 1.
REQ-015 SHALL update count in the cycle after the edge: +1 push only, -1 pop only, unchanged for both or neither.
REQ-016 SHALL derive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL), all from registered state only.
REQ-017 SHALL, with FWFT=0, load rdata with the head word on the edge that accepts a pop (latency 1 cycle); rdata holds at all other times.
REQ-018 SHALL, with FWFT=1, present the head word on rdata whenever empty=0 (0 cycles after data becomes visible); a pop presents the next word after the edge; rdata is don't-care when empty=1.
REQ-019 SHALL make a word written on edge N poppable from edge N+1 (count/empty visible after edge N).
REQ-020 SHALL pulse overflow for one cycle after an edge where write=1, full=1, read=0; the write is dropped and state is unchanged.
REQ-021 SHALL pulse underflow for one cycle after an edge where read=1 and empty=1; state is unchanged.

Reset
REQ-022 SHALL, on rising clock with rst=1, set both pointers and count to 0, rdata to 0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_LEVEL=0), overflow=0, underflow=0.
REQ-023 SHALL give rst priority over simultaneous write/read; requests in the reset cycle are discarded; storage contents are not reset.

Structure
REQ-024 SHALL place pointer-width and count-width localparam derivations in shared header fifo_defs, reused by later FIFO variants.
REQ-025 SHALL instantiate one sub-module fifo_ram: DEPTH x WIDTH storage with synchronous write port and asynchronous read port; control logic stays in sync_fifo.
REQ-026 SHALL reject at elaboration DEPTH not a power of two, AF_LEVEL>DEPTH, or AE_LEVEL>=DEPTH.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-027 SHALL cover this case: reset, push 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at 4; pop four times (FWFT=0) -> rdata 0x11,0x22,0x33,0x44 one cycle after each pop, empty at end.
REQ-028 SHALL cover this case: when full, write 0x55 without read -> overflow pulses one cycle, count stays 4, later pops return no 0x55.
REQ-029 SHALL cover this case: when full, read+write 0x66 in the same cycle -> count stays 4, full stays 1; the fifth pop order ends with 0x66.
REQ-030 SHALL cover this case: when empty, read+write 0x77 -> underflow pulses, count=1, next pop returns 0x77.
REQ-031 SHALL cover this case: FWFT=1, push 0xA5 -> rdata=0xA5 with empty=0 the cycle after push, before any read asserted.
REQ-032 SHALL cover this case: 10 push/pop cycles (pointer wrap twice), then rst mid-stream with write=1 -> next cycle count=0, empty=1, rdata=0, overflow=0, underflow=0.
